router_port_rx: RTL and testbench



---
 rtl/router_pkg.sv | 16 +
 rtl/rx_fifo.sv | 69 ++++++
 rtl/router_port_rx.sv | 160 ++++++++++++++++
 tb/tb_router_port_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router output-port receive path.
//   BYTE_W     : width of one deserialised byte
//   PKT_CNT_W  : width of the completed-packet counter
//   rx_state_e : receiver framing state (SYNC, IDLE, RECV)
package router_pkg;

  localparam int BYTE_W    = 8;
  localparam int PKT_CNT_W = 16;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    RECV = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous first-word-fall-through FIFO of {last, byte} entries.
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset (clears pointers/count)
//   push, push_data  : write request and {last, byte} entry
//   pop              : read request; ignored when empty
//   rd_data          : head entry, forced to zero while empty
//   full, empty      : occupancy flags derived from the registered count
//   count            : number of occupied entries
// A push while full is only accepted when a pop happens on the same edge.
module rx_fifo
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic [BYTE_W:0]               push_data,
  input  logic                          pop,
  output logic [BYTE_W:0]               rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BYTE_W:0] mem_q [FIFO_DEPTH];
  logic            do_push;
  logic            do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(FIFO_DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // Power-of-two depth: pointers wrap naturally.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; validity is carried by the count.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/router_port_rx.sv
// Serial receiver for one router output port. Deserialises the arbitrated
// 1-bit stream LSB-first into bytes and queues them with an end-of-packet flag.
// Optional feature macro: RX_PKT_COUNT_EN (builds the completed-packet counter;
// otherwise pkt_count is tied to zero).
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   rx_frame_n, rx_valid_n  : active-low frame and bit-valid from the arbiter
//   rx_din                  : serial data bit
//   byte_data, byte_last    : FIFO head byte and its end-of-packet flag
//   byte_valid, byte_ready  : byte-level handshake (pop on valid && ready)
//   fifo_count              : occupied FIFO entries
//   err_partial             : one-cycle pulse, packet ended off a byte boundary
//   ovf                     : one-cycle pulse, completed byte dropped (FIFO full)
//   pkt_count               : completed packets written with their last byte
module router_port_rx
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          rx_frame_n,
  input  logic                          rx_valid_n,
  input  logic                          rx_din,
  output logic [BYTE_W-1:0]             byte_data,
  output logic                          byte_last,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_partial,
  output logic                          ovf,
  output logic [PKT_CNT_W-1:0]          pkt_count
);

  rx_state_e       state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [BYTE_W-2:0] shift_q, shift_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic            push;
  logic            push_ok;
  logic            pop_ok;
  logic            push_last;
  logic [BYTE_W-1:0] push_byte;
  logic            fifo_full;
  logic            fifo_empty;
  logic [BYTE_W:0] head;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    err_d     = 1'b0;
    push      = 1'b0;
    // The 8th bit goes straight into the byte; only bits 0..6 are held.
    push_byte = {rx_din, shift_q};
    push_last = rx_frame_n;
    unique case (state_q)
      SYNC: begin
        // Never join a packet already in flight after reset.
        if (rx_frame_n) state_d = IDLE;
      end
      IDLE: begin
        if (!rx_frame_n) begin
          state_d = RECV;
          if (!rx_valid_n) begin
            shift_d[0] = rx_din;
            cnt_d      = 3'd1;
          end
        end
      end
      RECV: begin
        if (!rx_valid_n) begin
          if (cnt_q == 3'd7) begin
            push  = 1'b1;
            cnt_d = 3'd0;
            if (rx_frame_n) state_d = IDLE;
          end else if (rx_frame_n) begin
            err_d   = 1'b1;
            cnt_d   = 3'd0;
            state_d = IDLE;
          end else begin
            shift_d[cnt_q] = rx_din;
            cnt_d          = cnt_q + 3'd1;
          end
        end else if (rx_frame_n) begin
          // Frame dropped on a non-data cycle: the packet has no last byte.
          err_d   = 1'b1;
          cnt_d   = 3'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = SYNC;
        cnt_d   = 3'd0;
      end
    endcase
    pop_ok  = byte_ready && !fifo_empty;
    // A simultaneous pop frees a slot, so a full FIFO only drops without one.
    ovf_d   = push && fifo_full && !pop_ok;
    push_ok = push && !ovf_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SYNC;
      cnt_q   <= 3'd0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    shift_q <= shift_d;
  end

  rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_ok),
    .push_data ({push_last, push_byte}),
    .pop       (pop_ok),
    .rd_data   (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef RX_PKT_COUNT_EN
  logic [PKT_CNT_W-1:0] pkt_q, pkt_d;

  always_comb begin
    pkt_d = pkt_q;
    if (push_ok && push_last) pkt_d = pkt_q + PKT_CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pkt_q <= '0;
    else          pkt_q <= pkt_d;
  end

  assign pkt_count = pkt_q;
`else
  assign pkt_count = '0;
`endif

  assign byte_data   = head[BYTE_W-1:0];
  assign byte_last   = head[BYTE_W];
  assign byte_valid  = !fifo_empty;
  assign err_partial = err_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_router_port_rx.sv
// Self-checking bench for router_port_rx: directed packets, scoreboard of
// expected {last, byte} entries compared whenever a byte is accepted.
`timescale 1ns/1ps
module tb_router_port_rx;

  localparam int DEPTH = 4;
`ifdef RX_PKT_COUNT_EN
  localparam bit PKT_EN = 1'b1;
`else
  localparam bit PKT_EN = 1'b0;
`endif

  logic        clock      = 1'b0;
  logic        reset_n    = 1'b0;
  logic        rx_frame_n = 1'b1;
  logic        rx_valid_n = 1'b1;
  logic        rx_din     = 1'b0;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_valid;
  logic [2:0]  fifo_count;
  logic        err_partial;
  logic        ovf;
  logic [15:0] pkt_count;

  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          err_seen = 0;
  int          ovf_seen = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  mon_e;
  logic [15:0] exp_pkt  = 16'd0;

  always #5 clock = ~clock;

  router_port_rx #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_frame_n  (rx_frame_n),
    .rx_valid_n  (rx_valid_n),
    .rx_din      (rx_din),
    .byte_data   (byte_data),
    .byte_last   (byte_last),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .fifo_count  (fifo_count),
    .err_partial (err_partial),
    .ovf         (ovf),
    .pkt_count   (pkt_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pulse counting and scoreboard pops, sampled on the falling edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (err_partial) err_seen++;
      if (ovf)         ovf_seen++;
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pop_unexpected: got %0h expected no byte", {byte_last, byte_data});
        end else begin
          mon_e = exp_q.pop_front();
          chk("pop_byte", 32'({byte_last, byte_data}), 32'(mon_e));
        end
      end
    end
  end

  task automatic cyc(input logic f, input logic v, input logic d);
    rx_frame_n = f;
    rx_valid_n = v;
    rx_din     = d;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic last);
    exp_q.push_back({last, b});
    if (last && PKT_EN) exp_pkt++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic keep);
    for (int i = 0; i < 8; i++) cyc((i == 7) && last, 1'b0, b[i]);
    if (keep) expect_byte(b, last);
  endtask

  task automatic start_pkt();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic drain(input string name);
    byte_ready = 1'b1;
    for (int k = 0; k < 40 && byte_valid; k++) cyc(1'b1, 1'b1, 1'b0);
    // One more accept attempt with the FIFO empty must be harmless.
    cyc(1'b1, 1'b1, 1'b0);
    byte_ready = 1'b0;
    chk({name, "_count0"}, 32'(fifo_count), 32'd0);
    chk({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_data",  32'(byte_data),  32'd0);
    chk("rst_last",  32'(byte_last),  32'd0);
    chk("rst_err",   32'(err_partial), 32'd0);
    chk("rst_ovf",   32'(ovf),        32'd0);
    chk("rst_pkt",   32'(pkt_count),  32'd0);
    reset_n = 1'b1;

    // Single-byte packet 0xA5, valid exactly after the 8th bit
    start_pkt();
    b = 8'hA5;
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, b[i]);
    chk("a5_valid_before", 32'(byte_valid), 32'd0);
    cyc(1'b1, 1'b0, b[7]);
    expect_byte(b, 1'b1);
    chk("a5_valid", 32'(byte_valid), 32'd1);
    chk("a5_data",  32'(byte_data),  32'hA5);
    chk("a5_last",  32'(byte_last),  32'd1);
    chk("a5_count", 32'(fifo_count), 32'd1);
    drain("a5");

    // Three-byte packet held in the FIFO, then drained in order
    start_pkt();
    send_byte(8'h01, 1'b0, 1'b1);
    send_byte(8'h02, 1'b0, 1'b1);
    send_byte(8'h03, 1'b1, 1'b1);
    chk("p3_count", 32'(fifo_count), 32'd3);
    chk("p3_head",  32'({byte_last, byte_data}), 32'h001);
    drain("p3");

    // Packet ending after 5 data bits, then a clean 0x3C packet
    err_seen = 0;
    start_pkt();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("part5_pulse", 32'(err_partial), 32'd1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("part5_pulse_end", 32'(err_partial), 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("part5_once",  32'(err_seen),   32'd1);
    chk("part5_count", 32'(fifo_count), 32'd0);
    start_pkt();
    send_byte(8'h3C, 1'b1, 1'b1);
    chk("p3c_count", 32'(fifo_count), 32'd1);
    drain("p3c");

    // Frame dropped on a non-data cycle mid-byte
    err_seen = 0;
    start_pkt();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("part3_once",  32'(err_seen),   32'd1);
    chk("part3_count", 32'(fifo_count), 32'd0);

    // Overflow: 5-byte packet into a 4-entry FIFO
    ovf_seen = 0;
    start_pkt();
    send_byte(8'h10, 1'b0, 1'b1);
    send_byte(8'h11, 1'b0, 1'b1);
    send_byte(8'h12, 1'b0, 1'b1);
    send_byte(8'h13, 1'b0, 1'b1);
    chk("ovf_none_yet", 32'(ovf), 32'd0);
    send_byte(8'h14, 1'b1, 1'b0);
    chk("ovf_pulse", 32'(ovf),        32'd1);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    cyc(1'b1, 1'b1, 1'b0);
    chk("ovf_pulse_end", 32'(ovf),      32'd0);
    chk("ovf_once",      32'(ovf_seen), 32'd1);
    chk("ovf_pkt",       32'(pkt_count), 32'(exp_pkt));

    // Full FIFO, push and pop on the same edge
    start_pkt();
    b = 8'h55;
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, b[i]);
    byte_ready = 1'b1;
    cyc(1'b1, 1'b0, b[7]);
    byte_ready = 1'b0;
    expect_byte(b, 1'b1);
    chk("pp_count", 32'(fifo_count), 32'd4);
    chk("pp_ovf",   32'(ovf),        32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("pp_ovf_total", 32'(ovf_seen), 32'd1);
    chk("pp_pkt", 32'(pkt_count), 32'(exp_pkt));
    drain("pp");

    // Reset mid-packet, released while a packet is already streaming
    start_pkt();
    send_byte(8'h21, 1'b1, 1'b1);
    start_pkt();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_valid", 32'(byte_valid), 32'd0);
    chk("mid_rst_pkt",   32'(pkt_count),  32'd0);
    exp_q.delete();
    exp_pkt = 16'd0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'(i % 3 == 0));
    chk("sync_count", 32'(fifo_count), 32'd0);
    chk("sync_valid", 32'(byte_valid), 32'd0);
    start_pkt();
    send_byte(8'h7E, 1'b1, 1'b1);
    chk("post_sync_count", 32'(fifo_count), 32'd1);
    chk("post_sync_pkt",   32'(pkt_count),  32'(exp_pkt));
    drain("post_sync");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
